block_data_memory: RTL and testbench
====================================

// Module: block_data_memory
// PURPOSE
//   Backing store behind the cached data memory. Serves whole-block reads (line
//   allocate) and whole-block writes (dirty write-back) with a fixed multi-cycle
//   latency and a one-cycle ack handshake. The cache controller stalls the
//   pipeline while a request is outstanding. The storage array is named memory,
//   one entry per block, so the bench can dump words hierarchically.
// PARAMETERS
//   pBlockSize   32     bytes per block; power of two; block width = pBlockSize*8 bits
//   pMemorySize  16384  total bytes; multiple of pBlockSize; entries = pMemorySize/pBlockSize
//   pLatency     10     cycles from request acceptance to ack; >= 1
// PORTS
//   clk_i     in   1                single clock, rising edge
//   rst_i     in   1                asynchronous, active-low reset
//   enable_i  in   1                request valid
//   write_i   in   1                1 = block write, 0 = block read; sampled with enable_i
//   addr_i    in   32               byte address; low log2(pBlockSize) bits ignored
//   data_i    in   pBlockSize*8     write block; sampled at acceptance
//   ack_o     out  1                one-cycle completion pulse
//   data_o    out  pBlockSize*8     read block; valid while ack_o=1 after a read
// BEHAVIOUR
//   - Reset (rst_i=0, async): state=IDLE, counter=0, ack_o=0, data_o=0, latched
//     request cleared. memory[] is NOT reset (preloaded by bench).
//   - Block index = (addr_i / pBlockSize) mod (pMemorySize/pBlockSize); upper
//     address bits wrap silently, no error.
//   - FSM states:
//     IDLE: ack_o=0. Rising edge with enable_i=1 accepts: latch index, write_i,
//       data_i; counter <= pLatency-1; go BUSY.
//     BUSY: inputs ignored (latched copy used). Counter decrements each edge;
//       on the edge where counter==0, go ACK: read -> data_o <= memory[idx];
//       write -> memory[idx] <= latched data, data_o unchanged.
//     ACK: ack_o=1 for exactly one cycle; enable_i ignored; next edge -> IDLE.
//   - Latency: acceptance at edge E0 -> ack_o high from edge E(pLatency) to
//     E(pLatency+1). Minimum back-to-back spacing is pLatency+2 edges (one IDLE
//     cycle mandatory between requests).
//   - data_o holds its last read value outside ACK; only meaningful in ACK after a read.
//   - enable_i held high through ACK and into IDLE starts a NEW request at the
//     IDLE edge; the cache must drop enable_i on the ack cycle.
//   - Write is committed only on entry to ACK; reset during BUSY aborts with
//     memory unchanged and no ack.
//   - ack_o is a registered output (no combinational path from inputs).
// TESTING
//   1. Reset low, enable_i=1 -> ack_o=0, data_o=0; after release with
//      enable_i=0, ack_o stays 0 for 20 cycles.
//   2. Preload memory[1]=256'hA5..A5; read addr 0x20 at E0, pLatency=10 ->
//      ack_o high only between E10 and E11, data_o=256'hA5..A5.
//   3. Write 0x40 with data 256'h1234...; change data_i/addr_i during BUSY ->
//      memory[2]=256'h1234... after ack; read-back of 0x5C returns same block.
//   4. Address wrap: read 0x4000 + 0x20 (pMemorySize=16384) -> returns memory[1].
//   5. Hold enable_i=1 across ack -> second request accepted one cycle after
//      ack falls; second ack exactly pLatency+2 edges after first.
//   6. Write 0x60, assert rst_i=0 at 5th BUSY cycle -> ack_o never rises,
//      memory[3] unchanged, state IDLE after release.

Source files
------------

// File: rtl/block_data_memory.sv
// Block-granular backing store: whole-block reads and writes complete after a
// fixed latency and are acknowledged with a single-cycle registered pulse.
module block_data_memory #(
   parameter int unsigned pBlockSize  = 32,
   parameter int unsigned pMemorySize = 16384,
   parameter int unsigned pLatency    = 10
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    enable_i,
   input  logic                    write_i,
   input  logic [31:0]             addr_i,
   input  logic [pBlockSize*8-1:0] data_i,
   output logic                    ack_o,
   output logic [pBlockSize*8-1:0] data_o
);

   localparam int unsigned BLOCK_W  = pBlockSize * 8;
   localparam int unsigned ENTRIES  = pMemorySize / pBlockSize;
   localparam int unsigned OFFSET_W = $clog2(pBlockSize);
   localparam int unsigned IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int unsigned CNT_W    = $clog2(pLatency + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   logic [BLOCK_W-1:0] memory [ENTRIES];

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic               write_reg, write_next;
   logic [BLOCK_W-1:0] wdata_reg, wdata_next;
   logic [BLOCK_W-1:0] data_reg, data_next;
   logic               ack_reg, ack_next;

   logic [31:0]        blk_addr;
   logic [IDX_W-1:0]   req_idx;
   logic               commit;

   // Upper address bits fold back onto the array without complaint.
   assign blk_addr = addr_i >> OFFSET_W;
   assign req_idx  = IDX_W'(blk_addr % ENTRIES);
   assign commit   = (state_reg == BUSY) && (count_reg == '0);

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      idx_next   = idx_reg;
      write_next = write_reg;
      wdata_next = wdata_reg;
      data_next  = data_reg;
      ack_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (enable_i) begin
               state_next = BUSY;
               count_next = CNT_W'(pLatency - 1);
               idx_next   = req_idx;
               write_next = write_i;
               wdata_next = data_i;
            end
         end
         BUSY: begin
            if (commit) begin
               state_next = ACK;
               ack_next   = 1'b1;
               if (!write_reg) begin
                  data_next = memory[idx_reg];
               end
            end else begin
               count_next = count_reg - CNT_W'(1);
            end
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= IDLE;
         count_reg <= '0;
         idx_reg   <= '0;
         write_reg <= 1'b0;
         wdata_reg <= '0;
         data_reg  <= '0;
         ack_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         idx_reg   <= idx_next;
         write_reg <= write_next;
         wdata_reg <= wdata_next;
         data_reg  <= data_next;
         ack_reg   <= ack_next;
      end
   end

   // Storage is never cleared; a reset while BUSY leaves state_reg IDLE, so no commit.
   always_ff @(posedge clk_i) begin
      if (commit && write_reg) begin
         memory[idx_reg] <= wdata_reg;
      end
   end

   assign ack_o  = ack_reg;
   assign data_o = data_reg;

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: expected acks (cycle and data) are
// queued when a request is accepted and retired by a negedge monitor.
module tb_block_data_memory;

   localparam int LAT = 10;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         enable_i = 1'b0;
   logic         write_i = 1'b0;
   logic [31:0]  addr_i = '0;
   logic [255:0] data_i = '0;
   logic         ack_o;
   logic [255:0] data_o;

   block_data_memory #(
      .pBlockSize (32),
      .pMemorySize(16384),
      .pLatency   (LAT)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .enable_i(enable_i),
      .write_i (write_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .ack_o   (ack_o),
      .data_o  (data_o)
   );

   always #5 clk_i = ~clk_i;

   int cycle = 0;
   always @(posedge clk_i) cycle <= cycle + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic         rd;
      logic [255:0] data;
      int           ack_cycle;
   } exp_t;

   exp_t         sb[$];
   logic [255:0] model [int];
   logic         ack_prev = 1'b0;
   exp_t         mon_e;

   function automatic int idx_of(input logic [31:0] addr);
      return int'((addr / 32) % 512);
   endfunction

   // Monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk_i) begin
      if (ack_o) begin
         check_val("ack_width", {255'd0, ack_prev}, 256'd0);
         if (sb.size() == 0) begin
            check_val("spurious_ack", 256'd1, 256'd0);
         end else begin
            mon_e = sb.pop_front();
            check_val("ack_latency", 256'(cycle), 256'(mon_e.ack_cycle));
            if (mon_e.rd) check_val("read_data", data_o, mon_e.data);
            $display("txn ack cycle=%0d rd=%0b data=%h", cycle, mon_e.rd, data_o);
         end
      end
      ack_prev = ack_o;
   end

   task automatic wait_done();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_i);
      if (sb.size() != 0) begin
         check_val("ack_timeout", 256'(sb.size()), 256'd0);
         sb.delete();
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                        input bit scramble);
      exp_t e;
      int   idx;
      idx = idx_of(addr);
      @(negedge clk_i);
      enable_i = 1'b1;
      write_i  = wr;
      addr_i   = addr;
      data_i   = data;
      @(posedge clk_i);
      #1;
      e.rd        = !wr;
      e.ack_cycle = cycle + LAT;
      if (wr) begin
         model[idx] = data;
         e.data     = '0;
      end else begin
         e.data = model[idx];
      end
      sb.push_back(e);
      enable_i = 1'b0;
      if (scramble) begin
         addr_i  = $urandom;
         data_i  = {8{$urandom}};
         write_i = ~wr;
      end
      wait_done();
   endtask

   logic [255:0] pat_a5, pat_1234, pat_cafe, pat_dead;
   int           c0;
   exp_t         e1, e2;

   initial begin
      pat_a5   = {32{8'hA5}};
      pat_1234 = {8{32'h12345678}};
      pat_cafe = {16{16'hCAFE}};
      pat_dead = {16{16'hDEAD}};

      // Reset held with a request pending: outputs stay cleared.
      enable_i = 1'b1;
      addr_i   = 32'h20;
      #23;
      check_val("rst_ack", {255'd0, ack_o}, 256'd0);
      check_val("rst_data", data_o, 256'd0);
      @(negedge clk_i);
      enable_i = 1'b0;
      rst_i    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         check_val("idle_ack", {255'd0, ack_o}, 256'd0);
      end

      // Preload block 1 via the port, then read it back at 0x20.
      issue(1'b1, 32'h20, pat_a5, 1'b0);
      issue(1'b0, 32'h20, '0, 1'b0);

      // Write with inputs scrambled while BUSY; read back from inside the block.
      issue(1'b1, 32'h40, pat_1234, 1'b1);
      check_val("mem2_dump", dut.memory[2], pat_1234);
      issue(1'b0, 32'h5C, '0, 1'b0);

      // Address wrap onto block 1.
      issue(1'b0, 32'h4020, '0, 1'b0);

      // enable_i held across the ack: second request lands LAT+2 edges later.
      @(negedge clk_i);
      enable_i = 1'b1;
      write_i  = 1'b0;
      addr_i   = 32'h20;
      @(posedge clk_i);
      #1;
      c0 = cycle;
      e1.rd = 1'b1; e1.data = model[1]; e1.ack_cycle = c0 + LAT;
      e2.rd = 1'b1; e2.data = model[2]; e2.ack_cycle = c0 + 2 * LAT + 2;
      sb.push_back(e1);
      sb.push_back(e2);
      addr_i = 32'h40;
      repeat (LAT + 2) @(posedge clk_i);
      #1;
      enable_i = 1'b0;
      wait_done();

      // Reset in the 5th BUSY cycle aborts a write to block 3.
      issue(1'b1, 32'h60, pat_cafe, 1'b0);
      @(negedge clk_i);
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h60;
      data_i   = pat_dead;
      @(posedge clk_i);
      #1;
      enable_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (15) @(negedge clk_i);
      check_val("abort_mem3", dut.memory[3], pat_cafe);
      check_val("abort_state", 256'(dut.state_reg), 256'd0);
      check_val("abort_ack", {255'd0, ack_o}, 256'd0);
      issue(1'b0, 32'h60, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
